// File: rtl/pipe_out_gen_if.sv
// Pipe-out endpoint handshake: FWFT data word, block-ready flag and read strobe.
interface pipe_out_gen_if;
    logic        pipe_out_read;
    logic [31:0] pipe_out_data;
    logic        pipe_out_ready;

    modport master (input pipe_out_read, output pipe_out_data, output pipe_out_ready);
    modport slave  (output pipe_out_read, input pipe_out_data, input pipe_out_ready);
endinterface

// File: rtl/pipe_out_gen.sv
// Pipe Out pattern source with a throttled virtual FIFO gating pipe_out_ready.
// Optional error injection enabled by defining PIPE_OUT_GEN_ERR_INJECT_EN.
module pipe_out_gen #(
    parameter int BLOCK_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    pipe_out_gen_if.master        pipe_out,
    input  logic                  throttle_set,
    input  logic [31:0]           throttle_val,
    input  logic [2:0]            pattern,
    output logic [31:0]           word_count,
    output logic [15:0]           underflow_count
`ifdef PIPE_OUT_GEN_ERR_INJECT_EN
    ,
    input  logic                  inject_err
`endif
);

    typedef enum logic [2:0] {
        MODE_COUNT = 3'd0,
        MODE_LFSR  = 3'd1,
        MODE_WALK  = 3'd2,
        MODE_ALT   = 3'd3,
        MODE_ZERO  = 3'd4
    } mode_t;

    localparam logic [16:0] BLOCK_LEVEL = 17'(BLOCK_WORDS);
    localparam logic [16:0] LEVEL_MAX   = 17'h10000;

    mode_t       mode;
    mode_t       reset_mode;
    logic [31:0] gen_word;
    logic [31:0] throttle;
    logic [16:0] level;
    logic        ready_reg;
    logic        read;
    logic        fill;

    function automatic logic [31:0] first_word(input mode_t m);
        case (m)
            MODE_COUNT: first_word = 32'h0000_0001;
            MODE_LFSR:  first_word = 32'h04C1_1DB7;
            MODE_WALK:  first_word = 32'h0000_0001;
            MODE_ALT:   first_word = 32'hAAAA_AAAA;
            default:    first_word = 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] next_word(input mode_t m, input logic [31:0] w);
        case (m)
            MODE_COUNT: next_word = w + 32'd1;
            MODE_LFSR:  next_word = {w[30:0], w[31] ^ w[21] ^ w[1] ^ w[0]};
            MODE_WALK:  next_word = {w[30:0], w[31]};
            MODE_ALT:   next_word = ~w;
            default:    next_word = 32'h0000_0000;
        endcase
    endfunction

    // Patterns 4..7 all collapse onto the constant-zero mode.
    assign reset_mode = (pattern > 3'd3) ? MODE_ZERO : mode_t'(pattern);
    assign read       = pipe_out.pipe_out_read;
    assign fill       = throttle[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            mode            <= reset_mode;
            gen_word        <= first_word(reset_mode);
            throttle        <= throttle_val;
            level           <= 17'd0;
            ready_reg       <= 1'b0;
            word_count      <= 32'd0;
            underflow_count <= 16'd0;
        end else begin
            ready_reg <= (level >= BLOCK_LEVEL);
            throttle  <= throttle_set ? throttle_val : {throttle[0], throttle[31:1]};
            if (read) begin
                gen_word   <= next_word(mode, gen_word);
                word_count <= word_count + 32'd1;
                if (level == 17'd0 && underflow_count != 16'hFFFF)
                    underflow_count <= underflow_count + 16'd1;
            end
            // A simultaneous fill and read leave the level unchanged.
            if (fill && !read && level != LEVEL_MAX)
                level <= level + 17'd1;
            else if (read && !fill && level != 17'd0)
                level <= level - 17'd1;
        end
    end

`ifdef PIPE_OUT_GEN_ERR_INJECT_EN
    logic err_pending;

    // The pending flag corrupts exactly one later read, never the read it coincides with.
    always_ff @(posedge clk) begin
        if (reset)
            err_pending <= 1'b0;
        else if (read && err_pending)
            err_pending <= 1'b0;
        else if (inject_err)
            err_pending <= 1'b1;
    end

    assign pipe_out.pipe_out_data = gen_word ^ {31'd0, err_pending};
`else
    assign pipe_out.pipe_out_data = gen_word;
`endif

    assign pipe_out.pipe_out_ready = ready_reg;

endmodule

// File: tb/tb_pipe_out_gen.sv
// Self-checking bench for pipe_out_gen: reset-value table, directed corner sequences
// and a randomized run scored against a sequence-index reference model.
module tb_pipe_out_gen;

    localparam int BLOCK = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        throttle_set = 1'b0;
    logic [31:0] throttle_val = 32'd0;
    logic [2:0]  pattern = 3'd0;
    logic        inject_err = 1'b0;
    logic [31:0] word_count;
    logic [15:0] underflow_count;

    int tests = 0;
    int fails = 0;

    pipe_out_gen_if pipe_out ();

    pipe_out_gen #(.BLOCK_WORDS(BLOCK)) dut (
        .clk             (clk),
        .reset           (reset),
        .pipe_out        (pipe_out.master),
        .throttle_set    (throttle_set),
        .throttle_val    (throttle_val),
        .pattern         (pattern),
        .word_count      (word_count),
        .underflow_count (underflow_count)
`ifdef PIPE_OUT_GEN_ERR_INJECT_EN
        ,
        .inject_err      (inject_err)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: the k-th word is derived from the read index, the throttle from a phase.
    int          m_mode, m_k, m_uf, m_level, m_phase;
    logic        m_ready, m_pend;
    logic [31:0] m_tval;
    logic [31:0] lfsr_q[$];

    function automatic logic [31:0] exp_word();
        logic [31:0] w;
        case (m_mode)
            0:       w = 32'(m_k + 1);
            1:       w = lfsr_q[m_k];
            2:       w = 32'd1 << (m_k % 32);
            3:       w = (m_k % 2 == 1) ? 32'h5555_5555 : 32'hAAAA_AAAA;
            default: w = 32'd0;
        endcase
        return w ^ {31'd0, m_pend};
    endfunction

    task automatic modelStep();
        logic rd, fl;
        logic [31:0] x;
        rd = pipe_out.pipe_out_read;
        if (reset) begin
            m_mode = int'(pattern); m_k = 0; m_uf = 0; m_level = 0; m_phase = 0;
            m_ready = 1'b0; m_pend = 1'b0; m_tval = throttle_val;
        end else begin
            fl = m_tval[m_phase];
            m_ready = (m_level >= BLOCK);
            if (rd) begin
                if (m_level == 0 && m_uf < 65535) m_uf++;
                m_k++;
            end
            if (fl && !rd && m_level < 65536) m_level++;
            else if (rd && !fl && m_level > 0) m_level--;
            if (throttle_set) begin m_tval = throttle_val; m_phase = 0; end
            else m_phase = (m_phase + 1) % 32;
`ifdef PIPE_OUT_GEN_ERR_INJECT_EN
            if (rd && m_pend) m_pend = 1'b0;
            else if (inject_err) m_pend = 1'b1;
`endif
        end
        while (lfsr_q.size() <= m_k) begin
            x = lfsr_q[lfsr_q.size() - 1];
            lfsr_q.push_back({x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]});
        end
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic checkOutput();
        check32("data", pipe_out.pipe_out_data, exp_word());
        check32("ready", 32'(pipe_out.pipe_out_ready), 32'(m_ready));
        check32("word_count", word_count, 32'(m_k));
        check32("underflow_count", 32'(underflow_count), 32'(m_uf));
    endtask

    task automatic applyStimulus(input logic rd, input logic tset, input logic [31:0] tv,
                                 input logic rst, input logic [2:0] pat, input logic inj);
        pipe_out.pipe_out_read = rd;
        throttle_set = tset;
        throttle_val = tv;
        reset = rst;
        pattern = pat;
        inject_err = inj;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic doReset(input logic [2:0] pat, input logic [31:0] tv);
        applyStimulus(1'b0, 1'b0, tv, 1'b1, pat, 1'b0);
    endtask

    typedef struct {
        logic [2:0]  pat;
        logic [31:0] tval;
        logic [31:0] exp_data;
    } reset_vec_t;

    reset_vec_t vecs[8];

    initial begin
        int n;
        logic [31:0] cur_tval;
        lfsr_q.push_back(32'h04C1_1DB7);
        pipe_out.pipe_out_read = 1'b0;

        vecs[0] = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[1] = '{3'd1, 32'h0000_0000, 32'h04C1_1DB7};
        vecs[2] = '{3'd2, 32'h1234_5678, 32'h0000_0001};
        vecs[3] = '{3'd3, 32'h0000_0001, 32'hAAAA_AAAA};
        vecs[4] = '{3'd4, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[5] = '{3'd5, 32'h8000_0000, 32'h0000_0000};
        vecs[6] = '{3'd6, 32'h0F0F_0F0F, 32'h0000_0000};
        vecs[7] = '{3'd7, 32'h0000_0000, 32'h0000_0000};

        for (int i = 0; i < 8; i++) begin
            doReset(vecs[i].pat, vecs[i].tval);
            check32("reset_data", pipe_out.pipe_out_data, vecs[i].exp_data);
            check32("reset_ready", 32'(pipe_out.pipe_out_ready), 32'd0);
            check32("reset_word_count", word_count, 32'd0);
        end

        // Fill at one word per cycle: level hits BLOCK after BLOCK edges, ready one edge later.
        doReset(3'd0, 32'hFFFF_FFFF);
        n = 0;
        while (pipe_out.pipe_out_ready !== 1'b1 && n < 300) begin
            applyStimulus(1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 3'd0, 1'b0);
            n++;
        end
        check32("fill_ready_latency", 32'(n), 32'(BLOCK + 1));

        for (int i = 0; i < 1000; i++) begin
            check32("counter_word", pipe_out.pipe_out_data, 32'(i + 1));
            applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 3'd0, 1'b0);
        end
        check32("counter_word_count", word_count, 32'd1000);

        doReset(3'd1, 32'h0);
        check32("lfsr_first", pipe_out.pipe_out_data, 32'h04C1_1DB7);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 3'd1, 1'b0);
        check32("lfsr_second", pipe_out.pipe_out_data, 32'h0982_3B6E);

        doReset(3'd0, 32'h0);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0);
        check32("underflow_count5", 32'(underflow_count), 32'd5);
        check32("underflow_ready", 32'(pipe_out.pipe_out_ready), 32'd0);
        check32("underflow_data", pipe_out.pipe_out_data, 32'd6);

        // One fill per 32 cycles: level reaches BLOCK on edge 32*(BLOCK-1)+1, ready on the next.
        doReset(3'd0, 32'h0000_0001);
        n = 0;
        while (pipe_out.pipe_out_ready !== 1'b1 && n < 32 * BLOCK + 100) begin
            applyStimulus(1'b0, 1'b0, 32'h0000_0001, 1'b0, 3'd0, 1'b0);
            n++;
        end
        check32("throttle_ready_latency", 32'(n), 32'(32 * (BLOCK - 1) + 2));
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 1'b0, 32'h0000_0001, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0000_0001, 1'b1, 3'd3, 1'b0);
        check32("midreset_data", pipe_out.pipe_out_data, 32'hAAAA_AAAA);
        check32("midreset_word_count", word_count, 32'd0);
        check32("midreset_underflow", 32'(underflow_count), 32'd0);

`ifdef PIPE_OUT_GEN_ERR_INJECT_EN
        doReset(3'd0, 32'hFFFF_FFFF);
        check32("inject_read1", pipe_out.pipe_out_data, 32'd1);
        applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 3'd0, 1'b0);
        check32("inject_read2", pipe_out.pipe_out_data, 32'd2);
        applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 3'd0, 1'b1);
        check32("inject_read3", pipe_out.pipe_out_data, 32'd2);
        applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 3'd0, 1'b0);
        check32("inject_read4", pipe_out.pipe_out_data, 32'd4);
        applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 3'd0, 1'b0);
`endif

        // Randomized traffic with occasional throttle reloads, resets and injections.
        cur_tval = 32'hFFFF_FFFF;
        doReset(3'($urandom_range(0, 7)), cur_tval);
        for (int i = 0; i < 4000; i++) begin
            logic tset;
            tset = ($urandom_range(0, 63) == 0);
            if (tset) cur_tval = $urandom | $urandom;
            applyStimulus(($urandom_range(0, 3) != 0), tset, cur_tval,
                          ($urandom_range(0, 499) == 0), 3'($urandom_range(0, 7)),
                          ($urandom_range(0, 29) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
